instr_enc: RTL and testbench
============================

# instr_enc

Instruction encoder and program loader for the WISC single-cycle core. It accepts one symbolic instruction per cycle (opcode plus register and immediate fields) over a valid/ready handshake. It range-checks the fields, packs them into the 16-bit WISC encoding, and writes the words sequentially into instruction memory starting at a programmable base. A run ends when HLT is written, or early if the address space is exhausted. It is the producer of the encoding that the core's decoder consumes, and is used for bench program loading and for boot.

## Interface
- `AW`, 16, instruction-memory address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load run. Honoured only in IDLE or DONE.
- `base_addr`  in  AW  first write address; sampled on `start`.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept a bundle; high only in state LOAD.
- `fld_op`  in  4  opcode, using the `defines.v` values.
- `fld_rd`  in  4  destination register; for B, {0, cond[2:0]}.
- `fld_rs`  in  4  first source register.
- `fld_rt`  in  4  second source register.
- `fld_imm`  in  16  two's-complement immediate, shift amount, or branch/jump offset.
- `im_we`  out  1  instruction-memory write strobe.
- `im_addr`  out  AW  write address.
- `im_wdata`  out  16  encoded instruction word.
- `err`  out  1  one-cycle pulse: the accepted bundle was rejected.
- `err_seen`  out  1  sticky; set by any `err`, cleared by `start`.
- `ovf`  out  1  sticky; the run ended by address exhaustion. Cleared by `start`.
- `done`  out  1  level; high in state DONE.
- `wcount`  out  AW+1  words written in the current run.

## Operation
- States: IDLE → LOAD (on `start`) → FLUSH (when HLT is accepted, or the last address is accepted) → DONE (next cycle).
- DONE → LOAD on `start`. `start` in LOAD or FLUSH is ignored.
- Encoding, with MSB first:
  - ADD, ADDZ, SUB, AND, NOR: op|rd|rs|rt.
  - SLL, SRL, SRA: op|rd|rs|imm[3:0]. Legal when imm is 0..15.
  - LW, SW: op|rd|rs|imm[3:0]. Legal when imm is −8..7.
  - LHB, LLB: op|rd|imm[7:0]. Legal when imm is −128..255.
  - B: op|rd[2:0]|imm[8:0]. Legal when rd[3]=0 and imm is −256..255.
  - JAL: op|imm[11:0]. Legal when imm is −2048..2047.
  - JR: op|0000|rs|0000.
  - HLT: op|0x000.
- Unused fields are ignored, not checked.
- Illegal bundle:
  - Not written; address and `wcount` unchanged.
  - `err` pulses and `err_seen` sets.
  - The run continues.
- Address:
  - A write-address register loads `base_addr` on `start` and increments after each legal write.
  - When a legal non-HLT word is accepted at address 2^AW−1, it is written, `ovf` sets, and the FSM enters FLUSH. There is no wrap.
- HLT at address 2^AW−1 ends the run normally, with `ovf`=0.
- Rejected HLT: no write and no state change. The FSM stays in LOAD.

## Timing
- Bundle accepted at edge N (`in_valid` & `in_ready`).
  - In cycle N+1: `im_we`, `im_addr` and `im_wdata` are valid, from registered outputs.
  - `err`, for a rejected bundle, also appears in cycle N+1.
- Throughput is one bundle per cycle in LOAD, with no bubbles.
- HLT accepted at edge N: state is FLUSH in N+1, so `in_ready`=0 and HLT is written; `done`=1 from N+2.
- Reset values: state IDLE; `in_ready`, `im_we`, `err`, `err_seen`, `ovf` and `done` are 0; `im_addr`, `im_wdata` and `wcount` are 0.
- Reset mid-run: any write still pending is dropped, so `im_we`=0 in the cycle after `rst`. The memory already written is left as is.
- `in_valid` without `in_ready`: the bundle is ignored. No error and no stall state.

## Structure
- Opcode constants live in the shared `defines.v`: ADD=0 … HLT=F.
- Field-range limits go in `defines.v` as named constants.
- One natural sub-module is `instr_pack`: the combinational field→word packer plus legality check, with outputs `word[15:0]` and `legal`. The FSM, address counter and output registers stay in `instr_enc`.

## Test plan
- `base_addr`=0x0040, stream ADD r3,r1,r2 / LLB r4,−1 / HLT.
  - Expect writes 0x0312@0x40, 0xB4FF@0x41, 0xF000@0x42.
  - Then `done`=1 and `wcount`=3.
- SW rd=1,rs=2,imm=−1, then B cond=3,imm=−2, then JAL imm=5, back-to-back. Expect 0x912F, 0xC7FE and 0xD005 on consecutive cycles.
- SLL r5,r6,imm=16, then SLL r5,r6,imm=15.
  - The first gives `err` pulse and no write.
  - The second gives 0x565F at the unchanged address, with `err_seen`=1.
- `AW`=4, `base_addr`=0xE, three ADDs.
  - Two are written at 0xE and 0xF; `ovf`=1 and `done`=1.
  - `in_ready`=0 before the third.
- Assert `rst` the cycle after an accept. Expect no `im_we`, all outputs at reset values, and `start` accepted afterwards.
- `start` pulsed in LOAD mid-stream: ignored, and the address sequence continues.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared WISC opcode values, field-range limits and loader state encoding.
package instr_enc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_ADDZ = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_NOR  = 4'h4,
      OP_SLL  = 4'h5,
      OP_SRL  = 4'h6,
      OP_SRA  = 4'h7,
      OP_LW   = 4'h8,
      OP_SW   = 4'h9,
      OP_LHB  = 4'hA,
      OP_LLB  = 4'hB,
      OP_B    = 4'hC,
      OP_JAL  = 4'hD,
      OP_JR   = 4'hE,
      OP_HLT  = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int SHIFT_MIN = 0;
   localparam int SHIFT_MAX = 15;
   localparam int MEM_MIN   = -8;
   localparam int MEM_MAX   = 7;
   localparam int LB_MIN    = -128;
   localparam int LB_MAX    = 255;
   localparam int BR_MIN    = -256;
   localparam int BR_MAX    = 255;
   localparam int JAL_MIN   = -2048;
   localparam int JAL_MAX   = 2047;

   // Immediates arrive as 16-bit two's complement.
   function automatic logic in_range(input logic [15:0] v, input int lo, input int hi);
      int s;
      s = int'($signed(v));
      return (s >= lo) && (s <= hi);
   endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational field-to-word packer with per-format immediate legality check.
module instr_pack
   import instr_enc_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs,
   input  logic [3:0]  rt,
   input  logic [15:0] imm,
   output logic [15:0] word,
   output logic        legal
);

   always_comb begin
      word  = 16'h0000;
      legal = 1'b1;
      case (opcode_t'(op))
         OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR: begin
            word = {op, rd, rs, rt};
         end
         OP_SLL, OP_SRL, OP_SRA: begin
            word  = {op, rd, rs, imm[3:0]};
            legal = in_range(imm, SHIFT_MIN, SHIFT_MAX);
         end
         OP_LW, OP_SW: begin
            word  = {op, rd, rs, imm[3:0]};
            legal = in_range(imm, MEM_MIN, MEM_MAX);
         end
         OP_LHB, OP_LLB: begin
            word  = {op, rd, imm[7:0]};
            legal = in_range(imm, LB_MIN, LB_MAX);
         end
         OP_B: begin
            word  = {op, rd[2:0], imm[8:0]};
            legal = !rd[3] && in_range(imm, BR_MIN, BR_MAX);
         end
         OP_JAL: begin
            word  = {op, imm[11:0]};
            legal = in_range(imm, JAL_MIN, JAL_MAX);
         end
         OP_JR: begin
            word = {op, 4'h0, rs, 4'h0};
         end
         OP_HLT: begin
            word = {op, 12'h000};
         end
         default: begin
            word  = 16'h0000;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_enc.sv
// WISC program loader: accepts field bundles, packs them and writes them
// sequentially into instruction memory until HLT or address exhaustion.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting bundles, one per cycle
// FLUSH | final word (HLT or last address) being written
// DONE  | run complete; start begins a new run
module instr_enc
   import instr_enc_pkg::*;
#(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    fld_op,
   input  logic [3:0]    fld_rd,
   input  logic [3:0]    fld_rs,
   input  logic [3:0]    fld_rt,
   input  logic [15:0]   fld_imm,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [15:0]   im_wdata,
   output logic          err,
   output logic          err_seen,
   output logic          ovf,
   output logic          done,
   output logic [AW:0]   wcount
);

   state_t        state, state_nxt;
   logic [AW-1:0] addr;
   logic [15:0]   word;
   logic          legal;
   logic          accept;
   logic          start_ok;
   logic          last_addr;
   logic          is_hlt;

   instr_pack u_pack (
      .op    (fld_op),
      .rd    (fld_rd),
      .rs    (fld_rs),
      .rt    (fld_rt),
      .imm   (fld_imm),
      .word  (word),
      .legal (legal)
   );

   assign in_ready  = (state == S_LOAD);
   assign done      = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
   assign last_addr = (addr == {AW{1'b1}});
   assign is_hlt    = (fld_op == OP_HLT);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
         S_LOAD:         if (accept && legal && (is_hlt || last_addr)) state_nxt = S_FLUSH;
         S_FLUSH:        state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         wcount   <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= 16'h0000;
         err      <= 1'b0;
         err_seen <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         im_we <= 1'b0;
         err   <= 1'b0;
         if (start_ok) begin
            addr     <= base_addr;
            wcount   <= '0;
            err_seen <= 1'b0;
            ovf      <= 1'b0;
         end else if (accept) begin
            if (legal) begin
               im_we    <= 1'b1;
               im_addr  <= addr;
               im_wdata <= word;
               wcount   <= wcount + (AW+1)'(1);
               // Address saturates at the top; the run ends there anyway.
               if (!last_addr) addr <= addr + AW'(1);
               if (!is_hlt && last_addr) ovf <= 1'b1;
            end else begin
               err      <= 1'b1;
               err_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc: driver runs an arithmetic reference model and
// queues expected writes/errors; a negedge monitor pops and compares them.
module tb_instr_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  fld_op, fld_rd, fld_rs, fld_rt;
   logic [15:0] fld_imm;
   logic        im_we;
   logic [15:0] im_addr;
   logic [15:0] im_wdata;
   logic        err, err_seen, ovf, done;
   logic [16:0] wcount;

   instr_enc #(.AW(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready),
      .fld_op(fld_op), .fld_rd(fld_rd), .fld_rs(fld_rs), .fld_rt(fld_rt), .fld_imm(fld_imm),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .err(err), .err_seen(err_seen), .ovf(ovf), .done(done), .wcount(wcount)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_err;
      int addr;
      int data;
      int due;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   // reference model state: 0 idle, 1 load, 2 flush, 3 done
   int   ms, maddr, mwc;
   bit   merrs, movf;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, want);
      end
   endtask

   // Spec-level encoder: legality from signed ranges, word from field arithmetic.
   function automatic void ref_encode(input int op, input int rd, input int rs, input int rt,
                                      input logic [15:0] imm, output int w, output bit ok);
      int s;
      s  = int'($signed(imm));
      ok = 1'b1;
      w  = 0;
      if (op <= 4) w = op * 4096 + rd * 256 + rs * 16 + rt;
      else if (op <= 7) begin
         ok = (s >= 0 && s <= 15);  w = op * 4096 + rd * 256 + rs * 16 + (s & 15);
      end else if (op <= 9) begin
         ok = (s >= -8 && s <= 7);  w = op * 4096 + rd * 256 + rs * 16 + (s & 15);
      end else if (op <= 11) begin
         ok = (s >= -128 && s <= 255); w = op * 4096 + rd * 256 + (s & 255);
      end else if (op == 12) begin
         ok = (rd < 8) && (s >= -256 && s <= 255); w = op * 4096 + (rd % 8) * 512 + (s & 511);
      end else if (op == 13) begin
         ok = (s >= -2048 && s <= 2047); w = op * 4096 + (s & 4095);
      end else if (op == 14) w = op * 4096 + rs * 16;
      else w = 16'hF000;
   endfunction

   task automatic cycle(input bit v, input bit st, input logic [15:0] ba,
                        input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [15:0] imm);
      int  w;
      bit  ok;
      exp_t e;
      @(negedge clk);
      in_valid = v; start = st; base_addr = ba;
      fld_op = op; fld_rd = rd; fld_rs = rs; fld_rt = rt; fld_imm = imm;
      chk("in_ready", {31'd0, in_ready}, {31'd0, ms == 1});
      case (ms)
         0, 3: if (st) begin
            ms = 1; maddr = int'(ba); mwc = 0; merrs = 0; movf = 0;
         end
         1: if (v) begin
            ref_encode(int'(op), int'(rd), int'(rs), int'(rt), imm, w, ok);
            e.due = cyc + 1;
            if (ok) begin
               e.is_err = 0; e.addr = maddr; e.data = w;
               q.push_back(e);
               mwc++;
               if (op == 4'hF) ms = 2;
               else if (maddr == 65535) begin movf = 1; ms = 2; end
               else maddr++;
            end else begin
               e.is_err = 1; e.addr = 0; e.data = 0;
               q.push_back(e);
               merrs = 1;
            end
         end
         default: ms = 3;
      endcase
      @(posedge clk);
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [15:0] imm);
      cycle(1'b1, 1'b0, 16'h0, op, rd, rs, rt, imm);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
   endtask

   task automatic pulse_start(input logic [15:0] ba);
      cycle(1'b0, 1'b1, ba, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
   endtask

   task automatic check_status(input string tag);
      #1;
      chk({tag, "_done"}, {31'd0, done}, {31'd0, ms == 3});
      chk({tag, "_wcount"}, {15'd0, wcount}, mwc);
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, movf});
      chk({tag, "_err_seen"}, {31'd0, err_seen}, {31'd0, merrs});
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_rst_we"}, {31'd0, im_we}, 0);
      chk({tag, "_rst_outs"}, {21'd0, in_ready, err, err_seen, ovf, done, wcount == 17'd0,
                              im_addr == 16'd0, im_wdata == 16'd0, 3'd0},
          32'h0000_0038);
      ms = 0; maddr = 0; mwc = 0; merrs = 0; movf = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [15:0] pick_imm();
      int corners[18] = '{-2049, -2048, -257, -256, -129, -128, -9, -8, -1,
                          0, 7, 8, 15, 16, 255, 256, 2047, 2048};
      if ($urandom_range(0, 2) == 0) return 16'($urandom);
      return 16'(corners[$urandom_range(0, 17)]);
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         bit   has;
         has = (q.size() > 0) && (q[0].due == cyc);
         if (im_we === 1'b1 || err === 1'b1) begin
            checks++;
            if (!has) begin
               failures++;
               $display("FAIL unexpected_out we=%0b err=%0b addr=%h data=%h", im_we, err, im_addr, im_wdata);
            end else begin
               e = q.pop_front();
               if (e.is_err) begin
                  if (!(err === 1'b1 && im_we === 1'b0)) begin
                     failures++;
                     $display("FAIL err_pulse actual we=%0b err=%0b required we=0 err=1", im_we, err);
                  end
               end else if (!(im_we === 1'b1 && err === 1'b0 && im_addr === e.addr[15:0] &&
                              im_wdata === e.data[15:0])) begin
                  failures++;
                  $display("FAIL write actual we=%0b err=%0b %h@%h required %h@%h",
                           im_we, err, im_wdata, im_addr, e.data[15:0], e.addr[15:0]);
               end
            end
         end else if (has) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_out required is_err=%0b %h@%h", e.is_err, e.data[15:0], e.addr[15:0]);
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = 16'h0; in_valid = 1'b0;
      fld_op = 4'h0; fld_rd = 4'h0; fld_rs = 4'h0; fld_rt = 4'h0; fld_imm = 16'h0;
      ms = 0; maddr = 0; mwc = 0; merrs = 0; movf = 0;
      repeat (3) @(posedge clk);
      do_reset("init");
      mon_en = 1'b1;

      // ADD r3,r1,r2 / LLB r4,-1 / HLT at 0x40
      pulse_start(16'h0040);
      send(4'h0, 4'd3, 4'd1, 4'd2, 16'h0);
      send(4'hB, 4'd4, 4'd0, 4'd0, 16'hFFFF);
      send(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
      idle(); idle();
      check_status("basic");
      chk("basic_wcount3", {15'd0, wcount}, 3);

      // back-to-back formats, rejected shift, start ignored mid-stream
      pulse_start(16'h0100);
      send(4'h9, 4'd1, 4'd2, 4'd0, 16'hFFFF);
      send(4'hC, 4'd3, 4'd0, 4'd0, 16'hFFFE);
      send(4'hD, 4'd0, 4'd0, 4'd0, 16'd5);
      send(4'h5, 4'd5, 4'd6, 4'd0, 16'd16);
      send(4'h5, 4'd5, 4'd6, 4'd0, 16'd15);
      cycle(1'b1, 1'b1, 16'h0800, 4'h2, 4'd1, 4'd2, 4'd3, 16'h0);
      send(4'hE, 4'd0, 4'd7, 4'd0, 16'h0);
      send(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
      idle(); idle();
      check_status("mixed");

      // address exhaustion: two writes at FFFE/FFFF, third refused
      pulse_start(16'hFFFE);
      send(4'h0, 4'd1, 4'd1, 4'd1, 16'h0);
      send(4'h0, 4'd2, 4'd2, 4'd2, 16'h0);
      send(4'h0, 4'd3, 4'd3, 4'd3, 16'h0);
      idle();
      check_status("ovf");

      // reset the cycle after an accept, then a fresh run
      pulse_start(16'h0200);
      send(4'h3, 4'd1, 4'd2, 4'd3, 16'h0);
      do_reset("midrun");
      pulse_start(16'h0300);
      send(4'h4, 4'd1, 4'd2, 4'd3, 16'h0);
      send(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
      idle(); idle();
      check_status("after_rst");

      // randomized runs
      for (int r = 0; r < 12; r++) begin
         logic [15:0] ba;
         ba = (r % 3 == 2) ? 16'(16'hFFFF - $urandom_range(0, 6)) : 16'($urandom);
         pulse_start(ba);
         for (int i = 0; i < 50; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 16'($urandom),
                  4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 4'($urandom), pick_imm());
         end
         if (ms == 1) send(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
         idle(); idle();
         check_status("rand");
      end

      idle(); idle();
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
